// File: rtl/reg_alu_pipe.sv
// Two-stage register file + ALU datapath with operand forwarding and an external load write port.
// Latency: result and flags registered 2 edges after issue (Q_valid pulses for one cycle).
// Backpressure: none; one op accepted per cycle whenever Op_valid is high.
module reg_alu_pipe #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Op_valid,
    input  logic [2:0]        ALU_s,
    input  logic [ADDR_W-1:0] RF_Ra_addr,
    input  logic [ADDR_W-1:0] RF_Rb_addr,
    input  logic [ADDR_W-1:0] RF_W_addr,
    input  logic              RF_W_en,
    input  logic              Ext_W_en,
    input  logic [ADDR_W-1:0] Ext_W_addr,
    input  logic [DATA_W-1:0] Ext_W_data,
    output logic [DATA_W-1:0] Q,
    output logic              Q_valid,
    output logic [3:0]        Flags
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam int MSB      = DATA_W - 1;

    logic [DATA_W-1:0] rf [NUM_REGS];

    logic              e_vld;
    logic              e_wen;
    logic [2:0]        e_op;
    logic [ADDR_W-1:0] e_waddr;
    logic [DATA_W-1:0] e_a;
    logic [DATA_W-1:0] e_b;

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic [3:0]        alu_flags;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              wb_en;

    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (e_op)
            3'b000: begin
                sum_ext = {1'b0, e_a} + {1'b0, e_b};
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (e_a[MSB] == e_b[MSB]) && (alu_res[MSB] != e_a[MSB]);
            end
            3'b001: begin
                // Carry of A + ~B + 1: set means no borrow.
                sum_ext = {1'b0, e_a} + {1'b0, ~e_b} + {{DATA_W{1'b0}}, 1'b1};
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[DATA_W];
                alu_v   = (e_a[MSB] != e_b[MSB]) && (alu_res[MSB] != e_a[MSB]);
            end
            3'b010:  alu_res = e_a & e_b;
            3'b011:  alu_res = e_a | e_b;
            3'b100:  alu_res = e_a ^ e_b;
            3'b101:  alu_res = ~e_a;
            3'b110:  alu_res = e_a << e_b[SHAMT_W-1:0];
            default: alu_res = e_a;
        endcase
        alu_flags = {(alu_res == '0), alu_res[MSB], alu_c, alu_v};
    end

    assign wb_en = e_vld && e_wen && (e_waddr != '0);

    // Operand priority: R0, in-flight E result, same-edge external write, array.
    always_comb begin
        op_a = rf[RF_Ra_addr];
        if (RF_Ra_addr == '0)
            op_a = '0;
        else if (wb_en && (e_waddr == RF_Ra_addr))
            op_a = alu_res;
        else if (Ext_W_en && (Ext_W_addr == RF_Ra_addr))
            op_a = Ext_W_data;
    end

    always_comb begin
        op_b = rf[RF_Rb_addr];
        if (RF_Rb_addr == '0)
            op_b = '0;
        else if (wb_en && (e_waddr == RF_Rb_addr))
            op_b = alu_res;
        else if (Ext_W_en && (Ext_W_addr == RF_Rb_addr))
            op_b = Ext_W_data;
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < NUM_REGS; i++)
                rf[i] <= '0;
            e_vld   <= 1'b0;
            e_wen   <= 1'b0;
            e_op    <= '0;
            e_waddr <= '0;
            e_a     <= '0;
            e_b     <= '0;
            Q       <= '0;
            Q_valid <= 1'b0;
            Flags   <= '0;
        end else begin
            e_vld <= Op_valid;
            if (Op_valid) begin
                e_wen   <= RF_W_en;
                e_op    <= ALU_s;
                e_waddr <= RF_W_addr;
                e_a     <= op_a;
                e_b     <= op_b;
            end

            Q_valid <= e_vld;
            if (e_vld) begin
                Q     <= alu_res;
                Flags <= alu_flags;
            end

            // ALU writeback beats a same-address external write on the same edge.
            if (Ext_W_en && (Ext_W_addr != '0) && !(wb_en && (e_waddr == Ext_W_addr)))
                rf[Ext_W_addr] <= Ext_W_data;
            if (wb_en)
                rf[e_waddr] <= alu_res;
        end
    end
endmodule

// File: tb/tb_reg_alu_pipe.sv
// Bench for reg_alu_pipe: directed test-plan steps followed by random traffic against a reference model.
module tb_reg_alu_pipe;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          Clk = 1'b0;
    logic          ResetN;
    logic          Op_valid;
    logic [2:0]    ALU_s;
    logic [AW-1:0] RF_Ra_addr, RF_Rb_addr, RF_W_addr;
    logic          RF_W_en;
    logic          Ext_W_en;
    logic [AW-1:0] Ext_W_addr;
    logic [DW-1:0] Ext_W_data;
    logic [DW-1:0] Q;
    logic          Q_valid;
    logic [3:0]    Flags;

    reg_alu_pipe #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clk(Clk), .ResetN(ResetN), .Op_valid(Op_valid), .ALU_s(ALU_s),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .RF_W_addr(RF_W_addr),
        .RF_W_en(RF_W_en), .Ext_W_en(Ext_W_en), .Ext_W_addr(Ext_W_addr),
        .Ext_W_data(Ext_W_data), .Q(Q), .Q_valid(Q_valid), .Flags(Flags)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: architectural registers plus the one op in flight.
    logic [DW-1:0] m_rf [NR];
    logic          p_vld, p_wen;
    logic [AW-1:0] p_waddr;
    logic [DW-1:0] p_res;
    logic [3:0]    p_flags;
    logic [DW-1:0] m_q;
    logic [3:0]    m_flags;
    logic          m_qv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags returned as {Z,N,C,V}; computed from integer arithmetic on the operand values.
    task automatic ref_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output logic [DW-1:0] r, output logic [3:0] f);
        int ua, ub, sa, sb, s;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin r = DW'(ua + ub); c = (ua + ub) > 65535; s = sa + sb; v = (s > 32767) || (s < -32768); end
            3'd1: begin r = DW'(ua - ub); c = (ua >= ub); s = sa - sb; v = (s > 32767) || (s < -32768); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = DW'(ua * (1 << (ub % 16)));
            default: r = a;
        endcase
        f = {(r == 0), r[DW-1], c, v};
    endtask

    function automatic logic [DW-1:0] operand(input logic [AW-1:0] addr);
        if (addr == 0) return '0;
        if (p_vld && p_wen && p_waddr == addr) return p_res;
        if (Ext_W_en && Ext_W_addr == addr) return Ext_W_data;
        return m_rf[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        p_vld = 0; p_wen = 0; p_waddr = '0; p_res = '0; p_flags = '0;
        m_q = '0; m_flags = '0; m_qv = 0;
    endtask

    task automatic model_edge();
        logic [DW-1:0] a, b, r;
        logic [3:0]    f;
        a = operand(RF_Ra_addr);
        b = operand(RF_Rb_addr);
        ref_alu(ALU_s, a, b, r, f);
        m_qv = p_vld;
        if (p_vld) begin
            m_q = p_res;
            m_flags = p_flags;
        end
        if (Ext_W_en && Ext_W_addr != 0 && !(p_vld && p_wen && p_waddr == Ext_W_addr))
            m_rf[Ext_W_addr] = Ext_W_data;
        if (p_vld && p_wen && p_waddr != 0)
            m_rf[p_waddr] = p_res;
        p_vld = Op_valid; p_wen = RF_W_en; p_waddr = RF_W_addr; p_res = r; p_flags = f;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
        check("q_valid", Q_valid, m_qv);
        check("q", Q, m_q);
        check("flags", Flags, m_flags);
    endtask

    task automatic set_op(input logic v, input logic [2:0] op, input logic [AW-1:0] ra,
                          input logic [AW-1:0] rb, input logic [AW-1:0] w, input logic wen);
        Op_valid = v; ALU_s = op; RF_Ra_addr = ra; RF_Rb_addr = rb; RF_W_addr = w; RF_W_en = wen;
    endtask

    task automatic set_ext(input logic en, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        Ext_W_en = en; Ext_W_addr = addr; Ext_W_data = data;
    endtask

    task automatic idle();
        set_op(0, 3'd0, 0, 0, 0, 0);
        set_ext(0, 0, 0);
    endtask

    task automatic ext_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        idle(); set_ext(1, addr, data); tick(); idle();
    endtask

    // Issue one op, let it complete, compare Q against a hand-derived constant.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [AW-1:0] ra,
                          input logic [AW-1:0] rb, input logic [AW-1:0] w, input logic wen,
                          input logic [DW-1:0] exp_q);
        set_op(1, op, ra, rb, w, wen); tick(); idle(); tick();
        check(tag, Q, exp_q);
    endtask

    initial begin
        ResetN = 0;
        idle();
        model_reset();
        #12;
        check("rst_q", Q, 0);
        check("rst_q_valid", Q_valid, 0);
        check("rst_flags", Flags, 0);
        @(posedge Clk); #1 ResetN = 1;

        // Basic ADD, single-cycle Q_valid, readback through MOV.
        ext_wr(1, 16'h0005);
        ext_wr(2, 16'h0003);
        set_op(1, 3'd0, 1, 2, 3, 1); tick(); idle();
        check("add_not_early", Q_valid, 0);
        tick();
        check("add_q", Q, 16'h0008);
        check("add_qv", Q_valid, 1);
        check("add_flags", Flags, 4'b0000);
        tick();
        check("qv_one_cycle", Q_valid, 0);
        run_op("mov_r3", 3'd7, 3, 0, 0, 0, 16'h0008);

        // Back-to-back dependency through forwarding.
        set_op(1, 3'd0, 1, 2, 3, 1); tick();
        set_op(1, 3'd1, 3, 1, 4, 1); tick(); idle();
        tick();
        check("fwd_sub_q", Q, 16'h0003);
        run_op("mov_r4", 3'd7, 4, 0, 0, 0, 16'h0003);

        // Flag corners and shift.
        ext_wr(7, 16'h8000);
        ext_wr(8, 16'h0001);
        run_op("sub_ovf_q", 3'd1, 7, 8, 9, 0, 16'h7FFF);
        check("sub_ovf_flags", Flags, 4'b0011);
        ext_wr(7, 16'hFFFF);
        run_op("add_wrap_q", 3'd0, 7, 8, 9, 0, 16'h0000);
        check("add_wrap_flags", Flags, 4'b1010);
        ext_wr(7, 16'h0001);
        ext_wr(10, 16'h0004);
        run_op("shl_q", 3'd6, 7, 10, 9, 0, 16'h0010);

        // R0 is hardwired zero.
        run_op("add_to_r0_q", 3'd0, 1, 2, 0, 1, 16'h0008);
        run_op("r0_after_alu", 3'd7, 0, 0, 0, 0, 16'h0000);
        ext_wr(0, 16'h0055);
        run_op("r0_after_ext", 3'd7, 0, 0, 0, 0, 16'h0000);

        // Same-edge ALU writeback and external write to R5.
        ext_wr(11, 16'h1234);
        set_op(1, 3'd7, 11, 0, 5, 1); tick();
        idle(); set_ext(1, 5, 16'hBEEF); tick(); idle();
        run_op("r5_alu_wins", 3'd7, 5, 0, 0, 0, 16'h1234);
        set_op(1, 3'd7, 6, 0, 0, 0); set_ext(1, 6, 16'h00AA); tick(); idle(); tick();
        check("ext_fwd_r6", Q, 16'h00AA);

        // Reset with an op in flight.
        set_op(1, 3'd0, 1, 2, 3, 1); tick(); idle();
        ResetN = 0;
        model_reset();
        #1;
        check("midrst_qv", Q_valid, 0);
        check("midrst_q", Q, 0);
        check("midrst_flags", Flags, 0);
        @(posedge Clk); #1 ResetN = 1;
        tick();
        check("midrst_no_qv", Q_valid, 0);
        tick();
        run_op("midrst_r3", 3'd7, 3, 0, 0, 0, 16'h0000);

        // Random traffic over a narrow address range to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            set_op($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                   AW'($urandom_range(0, 5)), AW'($urandom_range(0, 5)),
                   AW'($urandom_range(0, 5)), $urandom_range(0, 3) != 0);
            set_ext($urandom_range(0, 2) == 0, AW'($urandom_range(0, 5)), DW'($urandom));
            tick();
        end
        idle();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_alu_pipe.md
Name: reg_alu_pipe

Overview:
- Parametrised, two-stage pipelined register-file-plus-ALU datapath for the processor project.
- Successor to the fixed 16x16 register/ALU block.
- Adds configurable data width and register count, a second (external/load) write port, operand forwarding, a hardwired-zero R0, registered status flags, and a valid-qualified result.
- Sits between the controller (issues ops) and data memory (load path via the external write port).

Parameters:
DATA_W, 16, datapath and register width (>= 8)
ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
SHAMT_W, $clog2(DATA_W), width of the shift amount taken from operand B's LSBs

Ports:
Clk  input  1  single clock, all state updates on rising edge
ResetN  input  1  asynchronous, active-low reset
Op_valid  input  1  issue strobe; an op is accepted on every edge where high
ALU_s  input  3  ALU operation select
RF_Ra_addr  input  ADDR_W  operand A register
RF_Rb_addr  input  ADDR_W  operand B register
RF_W_addr  input  ADDR_W  ALU result destination
RF_W_en  input  1  write ALU result back to RF_W_addr
Ext_W_en  input  1  external (load) write enable
Ext_W_addr  input  ADDR_W  external write address
Ext_W_data  input  DATA_W  external write data
Q  output  DATA_W  registered ALU result of the last completed op
Q_valid  output  1  one-cycle pulse when Q is updated
Flags  output  4  registered {Z,N,C,V} of the last completed op

Behaviour:
- Reset (async, ResetN=0): all registers = 0, Q = 0, Q_valid = 0, Flags = 0, pipeline stage valid bits cleared. In-flight ops are discarded with no writeback. The clock is ignored while ResetN=0.
- Stage E capture: at edge k with Op_valid=1, capture opA, opB, ALU_s, RF_W_addr, RF_W_en and valid.
- Operand source priority, per operand:
  - address 0 -> 0
  - else E-stage op is valid, has wen, and its waddr matches -> combinational ALU result (forward)
  - else Ext_W_en=1 and Ext_W_addr matches -> Ext_W_data
  - else register array
- Stage W (edge k+1): if the E op is valid:
  - Q <= result, Flags <= flags, Q_valid <= 1
  - if wen and waddr != 0, RF[waddr] <= result
- Otherwise Q_valid <= 0, and Q and Flags hold.
- Latency: 2 edges from issue to Q_valid. Throughput: 1 op per cycle, no stalls.
- ALU_s encoding:
  - 000 ADD A+B
  - 001 SUB A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A
  - 110 SHL: A << B[SHAMT_W-1:0], zero fill
  - 111 MOV A
- Result is truncated to DATA_W.
- Flags:
  - Z = (result == 0)
  - N = result[DATA_W-1]
  - C = carry out of A+B (ADD) or of A+~B+1 (SUB; 1 means no borrow); 0 for other ops
  - V = signed overflow for ADD/SUB; 0 otherwise
- Ext write: RF[Ext_W_addr] <= Ext_W_data on any edge with Ext_W_en=1 and Ext_W_addr != 0.
- Same-edge ALU writeback and Ext write to the same address: the ALU writeback wins and the Ext data is dropped. Different addresses: both writes occur.
- R0: reads always 0; writes ignored; no forwarding from address 0. Q and Flags still reflect the computed result when the destination is R0.
- Op_valid=0: no state change in E except the valid bit clearing. Register array is untouched except by the Ext port.

Test Plan:
- Ext writes R1=0x0005, R2=0x0003; issue ADD Ra=1, Rb=2, W=3 -> Q=0x0008 and Q_valid high for exactly 1 cycle, 2 edges after issue; Flags=0000; a later MOV Ra=3 returns 0x0008.
- Back-to-back: ADD R3=R1+R2, then next cycle SUB Ra=3, Rb=1, W=4 -> forwarded, Q=0x0003; a later MOV R4 gives 0x0003.
- SUB 0x8000-0x0001 -> Q=0x7FFF, {Z,N,C,V}=0011. ADD 0xFFFF+0x0001 -> Q=0x0000, {Z,N,C,V}=1010. SHL 0x0001 by 0x0004 -> Q=0x0010.
- ADD with W=0 (result 0x0008) -> Q=0x0008, but a subsequent MOV Ra=0 gives Q=0x0000. Ext write to R0 also ignored.
- Same edge: ALU writeback to R5 (0x1234) and Ext write R5=0xBEEF -> R5 reads 0x1234. Ext write R6=0x00AA in the issue cycle of MOV Ra=6 -> Q=0x00AA.
- ResetN pulsed low one cycle after issuing ADD R1+R2->R3 -> Q_valid never asserts for that op; Q=0, Flags=0, R3 reads 0 after release.
